spinet_host: RTL and testbench

- Host-side SPI master that drives one node port of the spinet ring: MOSI, SCLK and SS out, MISO in. It sits directly upstream of the ring.
- Converts a parallel valid/ready word stream into full-duplex WIDTH-bit SPI frames. Returns each captured MISO word on a one-entry rx buffer.
- Uses the node's txready/rxready to decide when to send a data frame and when to send a null poll frame.

---
 rtl/spinet_pkg.sv | 16 +
 rtl/spi_shift_reg.sv | 44 ++++
 rtl/spinet_host.sv | 162 ++++++++++++++++
 tb/tb_spinet_host.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spinet_pkg.sv
// Shared constants and host state encoding for the spinet host-side SPI master.
package spinet_pkg;

  localparam int WIDTH_DEF = 14;
  localparam int NULL_MAX  = 64;
  localparam logic [NULL_MAX-1:0] NULL_WORD = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } host_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register: MSB goes out on a registered serial output, MISO enters at the LSB.
module spi_shift_reg #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_in_i,
  input  logic             sin_i,
  input  logic             shift_out_i,
  output logic             sout_o,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             sout_q, sout_d;

  always_comb begin
    sr_d   = sr_q;
    sout_d = sout_q;
    if (load_i) begin
      sr_d   = load_data_i;
      sout_d = load_data_i[WIDTH-1];
    end else begin
      if (shift_in_i)  sr_d   = {sr_q[WIDTH-2:0], sin_i};
      if (shift_out_i) sout_d = sr_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      sout_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      sout_q <= sout_d;
    end
  end

  assign sout_o = sout_q;
  assign word_o = sr_q;

endmodule

// File: rtl/spinet_host.sv
// Host-side SPI master for one spinet ring node: word stream in, full-duplex frames out,
// captured non-null words returned through a one-entry rx buffer.
module spinet_host
  import spinet_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CLKDIV = 2,
  parameter int GAP    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             node_txready,
  input  logic             node_rxready,
  output logic             MOSI,
  output logic             SCLK,
  output logic             SS,
  input  logic             MISO
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam int DW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GW  = $clog2(GAP + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  // The IDLE cycle that launches the next frame is itself SS-high time, so GAP lingers GAP-1 cycles.
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 1) ? GAP - 2 : 0);

  host_state_e      state_q, state_d;
  logic             en_q;
  logic [DW-1:0]    div_q, div_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sclk_q, sclk_d;
  logic             ss_q, ss_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  logic             tick, rx_free, tx_fire, capture;
  logic             sr_load, sr_shift_in, sr_shift_out, sr_sout;
  logic [WIDTH-1:0] sr_load_data, sr_word;

  assign tick     = (div_q == DIV_LAST);
  assign rx_free  = ~rx_valid_q | rx_ready;
  assign tx_ready = en_q & (state_q == S_IDLE) & node_txready & ~(rx_valid_q & ~rx_ready);
  assign tx_fire  = tx_valid & tx_ready;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    sclk_d       = sclk_q;
    ss_d         = ss_q;
    sr_load      = 1'b0;
    sr_load_data = tx_data;
    sr_shift_in  = 1'b0;
    sr_shift_out = 1'b0;
    capture      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q && rx_free && (tx_fire || node_rxready)) begin
          sr_load      = 1'b1;
          sr_load_data = tx_fire ? tx_data : NULL_WORD[WIDTH-1:0];
          ss_d         = 1'b0;
          div_d        = '0;
          bit_d        = '0;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            sr_shift_in = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = S_HOLD;
            else                   sr_shift_out = 1'b1;
          end
        end
      end
      S_HOLD: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          ss_d    = 1'b1;
          capture = 1'b1;
          gap_d   = '0;
          state_d = (GAP > 1) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d = rx_valid_q & ~rx_ready;
    rx_data_d  = rx_data_q;
    // Null replies carry no payload and must not overwrite the buffer.
    if (capture && (sr_word != '0)) begin
      rx_valid_d = 1'b1;
      rx_data_d  = sr_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= 1'b1;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  spi_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (sr_load),
    .load_data_i (sr_load_data),
    .shift_in_i  (sr_shift_in),
    .sin_i       (MISO),
    .shift_out_i (sr_shift_out),
    .sout_o      (sr_sout),
    .word_o      (sr_word)
  );

  assign MOSI     = sr_sout & ~ss_q;
  assign SCLK     = sclk_q;
  assign SS       = ss_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spinet_host.sv
// Scoreboard bench for spinet_host: an SPI slave model replays per-frame replies and checks MOSI words and
// frame timing; an rx monitor checks returned words; a second instance checks back-to-back timing at CLKDIV=1, GAP=1.
module tb_spinet_host;

  localparam int W    = 14;
  localparam int CD   = 2;
  localparam int LOWN = CD * (2 * W + 2);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0, tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, rx_ready = 1'b1;
  logic         node_txready = 1'b0, node_rxready = 1'b0;
  logic         MOSI, SCLK, SS;
  logic         MISO = 1'b0;

  logic [W-1:0] tx_data_b, rx_data_b;
  logic         tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
  logic         node_txready_b, node_rxready_b, MOSI_b, SCLK_b, SS_b, MISO_b;
  assign tx_data_b      = 14'h01A5;
  assign tx_valid_b     = 1'b1;
  assign rx_ready_b     = 1'b1;
  assign node_txready_b = 1'b1;
  assign node_rxready_b = 1'b0;
  assign MISO_b         = 1'b0;

  spinet_host #(.WIDTH(W), .CLKDIV(CD), .GAP(2)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .node_txready(node_txready), .node_rxready(node_rxready),
    .MOSI(MOSI), .SCLK(SCLK), .SS(SS), .MISO(MISO)
  );

  spinet_host #(.WIDTH(W), .CLKDIV(1), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .node_txready(node_txready_b), .node_rxready(node_rxready_b),
    .MOSI(MOSI_b), .SCLK(SCLK_b), .SS(SS_b), .MISO(MISO_b)
  );

  typedef struct {
    logic [W-1:0] mosi;
    logic [W-1:0] reply;
  } frame_t;

  frame_t       frame_q[$];
  logic [W-1:0] rx_q[$];
  int total = 0;
  int bad = 0;
  int frames_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI slave model: supplies the queued reply MSB-first, collects MOSI on SCLK rises.
  initial begin : spi_mon
    logic         ss_p, sclk_p;
    frame_t       cur;
    logic [W-1:0] got;
    int           lown, nrise, nfall;
    ss_p = 1'b1; sclk_p = 1'b0; got = '0; lown = 0; nrise = 0; nfall = 0;
    cur.mosi = '0; cur.reply = '0;
    forever begin
      @(negedge clk); #1;
      if (ss_p && !SS) begin
        if (frame_q.size() == 0) begin
          check("frame_expected", frame_q.size(), 1);
          cur.mosi = '0; cur.reply = '0;
        end else begin
          cur = frame_q.pop_front();
        end
        got = '0; lown = 0; nrise = 0; nfall = 0;
        MISO = cur.reply[W-1];
      end
      if (!SS) begin
        lown++;
        if (SCLK && !sclk_p) begin
          got = {got[W-2:0], MOSI};
          nrise++;
        end
        if (!SCLK && sclk_p) begin
          nfall++;
          if (nfall < W) MISO = cur.reply[W-1-nfall];
        end
      end
      if (!ss_p && SS) begin
        if (rst) begin
          check("mosi_word", got, cur.mosi);
          check("ss_low_cycles", lown, LOWN);
          check("sclk_rises", nrise, W);
          check("lines_idle_after_frame", {SCLK, MOSI}, 0);
        end
        frames_done++;
        MISO = 1'b0;
      end
      ss_p = SS;
      sclk_p = SCLK;
    end
  end

  initial begin : rx_mon
    forever begin
      @(negedge clk); #1;
      if (rst && rx_valid && rx_ready) begin
        if (rx_q.size() == 0) check("rx_expected", rx_q.size(), 1);
        else                  check("rx_data", rx_data, rx_q.pop_front());
      end
    end
  end

  initial begin : mon_b
    int lo, hi, nf, t;
    logic p;
    lo = 0; hi = 0; nf = 0; t = 0; p = 1'b1;
    wait (rst);
    while (nf < 5 && t < 2000) begin
      @(negedge clk); #1;
      t++;
      if (!SS_b) begin
        if (p) begin
          if (nf > 0) check("b2b_ss_high", hi, 1);
          lo = 0;
        end
        lo++;
      end else begin
        if (!p) begin
          check("b2b_ss_low", lo, 30);
          nf++;
          hi = 0;
        end
        hi++;
      end
      p = SS_b;
    end
    check("b2b_frames_seen", nf, 5);
  end

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_in_time", frames_done >= n, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One decision in IDLE: data frame if tv&ntx, else poll if nrx, else nothing (rx buffer kept free).
  task automatic txn(input logic tv, input logic ntx, input logic nrx,
                     input logic [W-1:0] d, input logic [W-1:0] rep);
    int   n0;
    logic go_data, go;
    n0 = frames_done;
    go_data = tv & ntx;
    go = go_data | nrx;
    @(negedge clk);
    tx_valid = tv; node_txready = ntx; node_rxready = nrx; tx_data = d;
    if (go) begin
      frame_q.push_back('{mosi: (go_data ? d : '0), reply: rep});
      if (rep != '0) rx_q.push_back(rep);
    end
    #1 check("tx_ready_idle", tx_ready, ntx);
    if (go) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        tx_valid = 1'($urandom); node_txready = 1'($urandom);
        node_rxready = 1'($urandom); tx_data = W'($urandom);
        #1 check("tx_ready_busy", tx_ready, 0);
      end
      @(negedge clk);
      tx_valid = 1'b0; node_txready = 1'b0; node_rxready = 1'b0;
      wait_frames(n0 + 1);
    end else begin
      @(negedge clk);
      tx_valid = 1'b0; node_txready = 1'b0; node_rxready = 1'b0;
      idle_cycles(10);
      check("no_frame", frames_done, n0);
      check("ss_idle_high", SS, 1);
    end
    idle_cycles(4);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int n0;
    logic [W-1:0] d, rep;
    node_txready = 1'b1;
    idle_cycles(3);
    #1;
    check("rst_ss", SS, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("tx_ready_first_cycle", tx_ready, 0);
    @(negedge clk);
    #1 check("tx_ready_enabled", tx_ready, 1);
    node_txready = 1'b0;
    #1 check("tx_ready_follows_node", tx_ready, 0);
    idle_cycles(3);

    txn(1'b1, 1'b1, 1'b0, 14'h2A5C, 14'h1234);
    txn(1'b0, 1'b0, 1'b1, 14'h3333, 14'h0001);
    txn(1'b0, 1'b0, 1'b1, 14'h1111, 14'h0000);
    check("zero_reply_discarded", rx_valid, 0);
    txn(1'b1, 1'b0, 1'b1, 14'h3FFF, 14'h2222);
    txn(1'b1, 1'b1, 1'b1, 14'h3FFF, 14'h3FFF);
    txn(1'b0, 1'b1, 1'b0, 14'h0F0F, 14'h0101);

    // rx backpressure holds off polling until the buffer is consumed
    rx_ready = 1'b0;
    n0 = frames_done;
    @(negedge clk);
    tx_valid = 1'b1; node_txready = 1'b1; tx_data = 14'h0ABC;
    frame_q.push_back('{mosi: 14'h0ABC, reply: 14'h1555});
    rx_q.push_back(14'h1555);
    @(negedge clk);
    tx_valid = 1'b0; node_txready = 1'b0;
    wait_frames(n0 + 1);
    idle_cycles(3);
    #1 check("rx_held", rx_valid, 1);
    @(negedge clk);
    node_rxready = 1'b1; node_txready = 1'b1;
    idle_cycles(8);
    #1;
    check("blocked_no_frame", frames_done, n0 + 1);
    check("blocked_ss_high", SS, 1);
    check("blocked_tx_ready", tx_ready, 0);
    @(negedge clk);
    frame_q.push_back('{mosi: '0, reply: '0});
    node_txready = 1'b0;
    rx_ready = 1'b1;
    @(negedge clk);
    #1;
    check("unblocked_ss_low", SS, 0);
    check("unblocked_rx_valid", rx_valid, 0);
    node_rxready = 1'b0;
    wait_frames(n0 + 2);
    idle_cycles(4);
    check("null_reply_rx_valid", rx_valid, 0);

    for (int k = 0; k < 25; k++) begin
      d = W'($urandom);
      rep = W'($urandom);
      if ($urandom_range(3) == 0) rep = '0;
      txn(1'($urandom), 1'($urandom), 1'($urandom), d, rep);
    end

    // reset in the middle of a frame
    n0 = frames_done;
    @(negedge clk);
    node_rxready = 1'b1;
    frame_q.push_back('{mosi: '0, reply: 14'h0777});
    @(negedge clk);
    node_rxready = 1'b0;
    idle_cycles(19);
    rst = 1'b0;
    #1;
    check("abort_ss", SS, 1);
    check("abort_sclk", SCLK, 0);
    check("abort_mosi", MOSI, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_rx_data", rx_data, 0);
    node_txready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1 check("rerelease_tx_ready_first", tx_ready, 0);
    @(negedge clk);
    #1 check("rerelease_tx_ready", tx_ready, 1);
    node_txready = 1'b0;
    #1 check("rerelease_tx_ready_follow", tx_ready, 0);
    idle_cycles(3);
    check("abort_frame_ended", frames_done, n0 + 1);
    txn(1'b1, 1'b1, 1'b0, 14'h1C3A, 14'h2BCD);

    check("frame_q_empty", frame_q.size(), 0);
    check("rx_q_empty", rx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
